exe_mux_arbiter: RTL and testbench
==================================

# exe_mux_arbiter

Round-robin arbiter that shares the execution unit's 4:1 operand multiplexer between four requesters. It grants one requester at a time and drives the Gray-coded mux select for the winner. It issues a start pulse to the execution unit, waits for completion, acknowledges the requester, and releases the resource after the requester withdraws. It sits between the APB-side requesters and the `mux_4to1` / ALU datapath inside the execution unit.

## Interface
- `TIMEOUT`, default 16: cycles allowed in WAIT before forced release; used only with `ARB_TIMEOUT_EN`; legal range 2..255.

- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  4  level request, bit i = requester i; held until release.
- `exe_done`  in  1  one-cycle completion pulse from the execution unit.
- `gnt`  out  4  one-hot grant, registered; 0 when no owner.
- `sel`  out  2  Gray-coded mux select: owner 0→00, 1→01, 2→11, 3→10.
- `exe_start`  out  1  one-cycle start pulse to the execution unit.
- `ack`  out  4  one-hot, one-cycle completion pulse to the owner.
- `busy`  out  1  high in every state except IDLE.
- `timeout_err`  out  1  one-cycle pulse on forced release; tied 0 without `ARB_TIMEOUT_EN`.

## Operation
- FSM states: IDLE, START, WAIT, ACK, RELEASE. The encoding is free.
- IDLE:
  - If `req` is nonzero, pick the winner by round-robin search starting at index (ptr+1) mod 4.
  - Register `gnt`, `sel` and owner; go to START.
- START: `exe_start`=1 for exactly one cycle; go to WAIT.
- WAIT:
  - `exe_done`=1 → go to ACK.
  - With `ARB_TIMEOUT_EN` and the counter reaching TIMEOUT-1 without `exe_done` → pulse `timeout_err`, go to RELEASE with no `ack`.
- ACK: `ack[owner]`=1 for one cycle; go to RELEASE.
- RELEASE:
  - Stay while `req[owner]`=1.
  - When `req[owner]`=0: ptr←owner, `gnt`←0, go to IDLE.
- Round-robin pointer:
  - 2-bit, reset value 3, so requester 0 has first priority after reset.
  - Updates only on leaving RELEASE.
- `sel` keeps the last owner's code through IDLE. It changes only when a new grant is registered.
- `gnt` is stable and one-hot from START through RELEASE inclusive.
- `exe_done` outside WAIT is ignored. `exe_done` in the same cycle as the timeout condition counts as completion (ACK path).
- Withdrawal of `req[owner]` during START, WAIT or ACK is ignored; the transaction completes.
- Requests from non-owners while busy are held off. They are served in round-robin order after release.
- A requester that never drops `req` holds the resource indefinitely. This is a system-level obligation, not checked here.

## Timing
- Reset values (asynchronous, immediate on `rst_n`=0):
  - State IDLE, ptr=3, counter=0.
  - `gnt`=0, `sel`=00, `exe_start`=0, `ack`=0, `busy`=0, `timeout_err`=0.
- Reset mid-transaction aborts it with no `ack` and no `timeout_err`.
- Request sampled at edge k (in IDLE) → `gnt`, `sel`, `busy`, `exe_start` high during cycle k+1.
- `exe_start` high exactly in cycle k+1; WAIT from edge k+2.
- `exe_done` sampled at edge m (in WAIT) → `ack` high during cycle m+1.
- `req[owner]` sampled low at edge r (in RELEASE) → `gnt`=0 and `busy`=0 in cycle r+1.
- The next grant is registered no earlier than edge r+1, so there is a minimum one idle cycle between owners.
- Timeout:
  - The counter clears on entering WAIT and increments each WAIT cycle.
  - The forced release gives `timeout_err` high in the TIMEOUT-th cycle after entering WAIT, followed by RELEASE.
- All outputs are registered or decoded from state only (Moore). There is no combinational path from inputs to outputs.

## Configuration
- `ARB_TIMEOUT_EN` defined:
  - The WAIT watchdog counter (8-bit) is compiled in.
  - It forces release after TIMEOUT cycles and pulses `timeout_err`.
- `ARB_TIMEOUT_EN` undefined:
  - No counter; WAIT exits only on `exe_done`.
  - `timeout_err` is constant 0 and `TIMEOUT` is unused.

## Test plan
- Reset then `req`=0100: `gnt`=0100, `sel`=11, `exe_start` one cycle after sampling. `exe_done` pulse → `ack`=0100 next cycle. Drop req → `gnt`=0000, `busy`=0.
- `req`=1111 held, each requester dropping after its `ack`: grant order 0,1,2,3. `sel` sequence 00,01,11,10. Exactly one `exe_start` per grant.
- Owner 1 active and `req`=1011 (requesters 0, 1, 3); after release of 1: next grant is 3 (`sel`=10), then 0.
- `exe_done` pulsed in IDLE and in RELEASE: no state change, no `ack`. Owner drops `req` during WAIT: transaction still completes with `ack`.
- With `ARB_TIMEOUT_EN`, TIMEOUT=16, no `exe_done`: `timeout_err` pulses once after 16 WAIT cycles with `ack` never asserted. Without the macro, `busy` stays high 100 cycles.
- `rst_n` asserted in WAIT: all outputs 0 immediately, `sel`=00. After deassert, `req`=1000 is granted with `sel`=10, and ptr=3 gives requester 0 priority on a later `req`=1001.

Source files
------------

// File: rtl/exe_mux_arbiter.sv
// exe_mux_arbiter: round-robin owner of the execution unit's 4:1 operand mux with start/done/ack handshake.
// Define ARB_TIMEOUT_EN to compile in the WAIT watchdog that forces release and pulses timeout_err.
module exe_mux_arbiter #(
    parameter int TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       exe_done,
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic       exe_start,
    output logic [3:0] ack,
    output logic       busy,
    output logic       timeout_err
);
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] START   = 3'd1;
    localparam logic [2:0] WAIT    = 3'd2;
    localparam logic [2:0] ACK     = 3'd3;
    localparam logic [2:0] RELEASE = 3'd4;

    logic [2:0] state_q, state_d;
    logic [1:0] ptr_q, ptr_d, owner_q, owner_d, win;
    logic       tmo;

    if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
        $error("exe_mux_arbiter: TIMEOUT must be in 2..255");
    end

    // Scanning from the far end lets the nearest requester after ptr win.
    always_comb begin
        win = ptr_q;
        for (int i = 3; i >= 0; i--)
            if (req[ptr_q + 2'(i + 1)]) win = ptr_q + 2'(i + 1);
    end

`ifdef ARB_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;
    logic       tmo_q;
    assign tmo = state_q == WAIT && !exe_done && cnt_q == 8'(TIMEOUT - 1);
    always_comb cnt_d = state_q == START ? 8'd0 : state_q == WAIT ? cnt_q + 8'd1 : cnt_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 8'd0;
            tmo_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tmo_q <= tmo;
        end
    end
    assign timeout_err = tmo_q;
`else
    assign tmo         = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        case (state_q)
            IDLE: if (|req) begin
                state_d = START;
                owner_d = win;
            end
            START:   state_d = WAIT;
            WAIT:    state_d = exe_done ? ACK : tmo ? RELEASE : WAIT;
            ACK:     state_d = RELEASE;
            RELEASE: if (!req[owner_q]) begin
                state_d = IDLE;
                ptr_d   = owner_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= 2'd3;
            owner_q <= 2'd0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
        end
    end

    // owner_q only changes on a new grant, so sel holds the last owner's code through IDLE.
    assign busy      = state_q != IDLE;
    assign gnt       = busy ? 4'b0001 << owner_q : 4'b0000;
    assign sel       = {owner_q[1], ^owner_q};
    assign exe_start = state_q == START;
    assign ack       = state_q == ACK ? gnt : 4'b0000;
endmodule

// File: tb/tb_exe_mux_arbiter.sv
// tb_exe_mux_arbiter: directed bench for exe_mux_arbiter; outputs sampled 1ns after each rising edge.
module tb_exe_mux_arbiter;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = 4'b0000;
    logic       exe_done = 1'b0;
    logic [3:0] gnt, ack;
    logic [1:0] sel;
    logic       exe_start, busy, timeout_err;
    int         checks = 0;
    int         errors = 0;
    logic [1:0] sel_tab [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
    logic [3:0] oh_tab  [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

    exe_mux_arbiter #(.TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .exe_done(exe_done),
        .gnt(gnt), .sel(sel), .exe_start(exe_start), .ack(ack),
        .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        req = 4'b0000;
        exe_done = 1'b0;
        tick;
        tick;
        chk("rst_gnt", 8'(gnt), 8'h0);
        chk("rst_sel", 8'(sel), 8'h0);
        chk("rst_busy", 8'(busy), 8'h0);
        chk("rst_start", 8'(exe_start), 8'h0);
        chk("rst_ack", 8'(ack), 8'h0);
        chk("rst_tmo", 8'(timeout_err), 8'h0);
        rst_n = 1'b1;
    endtask

    task automatic serve(input int o, input logic [3:0] rq_during, input logic [3:0] rq_after);
        tick;
        chk("gnt", 8'(gnt), 8'(oh_tab[o]));
        chk("sel", 8'(sel), 8'(sel_tab[o]));
        chk("start", 8'(exe_start), 8'h1);
        chk("busy", 8'(busy), 8'h1);
        req = rq_during;
        tick;
        chk("start_off", 8'(exe_start), 8'h0);
        chk("ack_wait", 8'(ack), 8'h0);
        exe_done = 1'b1;
        tick;
        exe_done = 1'b0;
        chk("ack", 8'(ack), 8'(oh_tab[o]));
        chk("gnt_ack", 8'(gnt), 8'(oh_tab[o]));
        chk("tmo_ack", 8'(timeout_err), 8'h0);
        tick;
        chk("ack_off", 8'(ack), 8'h0);
        chk("gnt_rel", 8'(gnt), 8'(oh_tab[o]));
        chk("busy_rel", 8'(busy), 8'h1);
        req = rq_after;
        tick;
        chk("gnt_idle", 8'(gnt), 8'h0);
        chk("busy_idle", 8'(busy), 8'h0);
        chk("sel_idle", 8'(sel), 8'(sel_tab[o]));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset;
        req = 4'b0100;
        serve(2, 4'b0100, 4'b0000);

        do_reset;
        req = 4'b1111;
        serve(0, 4'b1111, 4'b1110);
        serve(1, 4'b1110, 4'b1100);
        serve(2, 4'b1100, 4'b1000);
        serve(3, 4'b1000, 4'b0000);

        req = 4'b0010;
        serve(1, 4'b1011, 4'b1001);
        serve(3, 4'b1001, 4'b0001);
        serve(0, 4'b0001, 4'b0000);

        exe_done = 1'b1;
        tick;
        exe_done = 1'b0;
        chk("idle_done_busy", 8'(busy), 8'h0);
        chk("idle_done_ack", 8'(ack), 8'h0);
        req = 4'b0100;
        tick;
        chk("drop_gnt", 8'(gnt), 8'h4);
        tick;
        req = 4'b0000;
        tick;
        chk("drop_busy", 8'(busy), 8'h1);
        chk("drop_ack0", 8'(ack), 8'h0);
        exe_done = 1'b1;
        tick;
        exe_done = 1'b0;
        chk("drop_ack", 8'(ack), 8'h4);
        req = 4'b0100;
        tick;
        exe_done = 1'b1;
        tick;
        exe_done = 1'b0;
        chk("rel_done_busy", 8'(busy), 8'h1);
        chk("rel_done_ack", 8'(ack), 8'h0);
        chk("rel_done_gnt", 8'(gnt), 8'h4);
        req = 4'b0000;
        tick;
        chk("rel_done_idle", 8'(busy), 8'h0);

        req = 4'b1000;
        tick;
        chk("wd_gnt", 8'(gnt), 8'h8);
        chk("wd_sel", 8'(sel), 8'h2);
        tick;
`ifdef ARB_TIMEOUT_EN
        chk("wd_tmo_early", 8'(timeout_err), 8'h0);
        for (int i = 0; i < 15; i++) begin
            tick;
            chk("wd_tmo_early", 8'(timeout_err), 8'h0);
            chk("wd_ack_early", 8'(ack), 8'h0);
        end
        tick;
        chk("wd_tmo", 8'(timeout_err), 8'h1);
        chk("wd_tmo_ack", 8'(ack), 8'h0);
        chk("wd_tmo_busy", 8'(busy), 8'h1);
        tick;
        chk("wd_tmo_once", 8'(timeout_err), 8'h0);
        chk("wd_rel_ack", 8'(ack), 8'h0);
        chk("wd_rel_busy", 8'(busy), 8'h1);
`else
        for (int i = 0; i < 100; i++) begin
            tick;
            chk("hold_busy", 8'(busy), 8'h1);
            chk("hold_tmo", 8'(timeout_err), 8'h0);
        end
        exe_done = 1'b1;
        tick;
        exe_done = 1'b0;
        chk("hold_ack", 8'(ack), 8'h8);
        tick;
`endif
        req = 4'b0000;
        tick;
        chk("wd_idle", 8'(busy), 8'h0);

        req = 4'b0001;
        tick;
        chk("pre_rst_gnt", 8'(gnt), 8'h1);
        tick;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_gnt", 8'(gnt), 8'h0);
        chk("arst_sel", 8'(sel), 8'h0);
        chk("arst_busy", 8'(busy), 8'h0);
        chk("arst_start", 8'(exe_start), 8'h0);
        chk("arst_ack", 8'(ack), 8'h0);
        req = 4'b0000;
        tick;
        chk("arst_ack2", 8'(ack), 8'h0);
        chk("arst_tmo", 8'(timeout_err), 8'h0);
        rst_n = 1'b1;
        req = 4'b1000;
        serve(3, 4'b1000, 4'b0000);
        req = 4'b1001;
        serve(0, 4'b1001, 4'b1000);
        serve(3, 4'b1000, 4'b0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
